// File: rtl/seq_det_pkg.sv
// Shared constants and types for the programmable serial sequence detector.
// Length limits and derived widths live here so every block agrees on them.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 16;
    localparam int MAX_LEN_LIM = 32;
    localparam int MIN_LEN     = 2;

    typedef enum logic {
        OVL_OFF = 1'b0,
        OVL_ON  = 1'b1
    } ovl_e;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_match.sv
// Masked pattern compare over the lowest len bits of the candidate window.
// Purely combinational; bits at or above len never affect the result.
module seq_det_match
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = len_w(MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] cand,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [MAX_LEN-1:0] mask,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    always_comb begin
        hit = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len) && mask[i] && (cand[i] != pattern[i])) begin
                hit = 1'b0;
            end
        end
    end

endmodule

// File: rtl/programmable_sequence_detector.sv
// Serial detector with a runtime pattern, per-bit mask and length,
// selectable overlap behaviour and a saturating hit counter.
module programmable_sequence_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = MAX_LEN_DEF,
    parameter int                 CNT_W       = 8,
    parameter int                 RST_LEN     = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(8'b11100111),
    localparam int                LEN_W       = len_w(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [MAX_LEN-1:0] cfg_mask,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    input  logic               in_valid,
    input  logic               in,
    output logic               dec,
    output logic [CNT_W-1:0]   hit_count,
    output logic               primed
);

    logic [MAX_LEN-1:0] win;
    logic [MAX_LEN-1:0] pattern_q;
    logic [MAX_LEN-1:0] mask_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   fill;
    ovl_e               ovl_q;

    logic [MAX_LEN-1:0] cand;
    logic [LEN_W-1:0]   len_clamped;
    logic [LEN_W-1:0]   fill_inc;
    logic               accept;
    logic               fill_ok;
    logic               hit;

    assign cand   = {win[MAX_LEN-2:0], in};
    assign accept = in_valid & ~cfg_we;
    assign primed = (fill >= len_q);

    // fill+1 is evaluated one bit wider so fill == all-ones cannot wrap
    assign fill_ok = ({1'b0, fill} + (LEN_W+1)'(1)) >= {1'b0, len_q};
    assign dec     = rst_n & accept & fill_ok & hit;

    seq_det_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .cand    (cand),
        .pattern (pattern_q),
        .mask    (mask_q),
        .len     (len_q),
        .hit     (hit)
    );

    always_comb begin
        len_clamped = cfg_len;
        if (int'(cfg_len) < MIN_LEN) begin
            len_clamped = LEN_W'(MIN_LEN);
        end else if (int'(cfg_len) > MAX_LEN) begin
            len_clamped = LEN_W'(MAX_LEN);
        end
    end

    always_comb begin
        fill_inc = fill;
        if (int'(fill) < MAX_LEN) begin
            fill_inc = fill + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win       <= '0;
            fill      <= '0;
            pattern_q <= RST_PATTERN;
            mask_q    <= '1;
            len_q     <= LEN_W'(RST_LEN);
            ovl_q     <= OVL_ON;
        end else if (cfg_we) begin
            pattern_q <= cfg_pattern;
            mask_q    <= cfg_mask;
            len_q     <= len_clamped;
            ovl_q     <= ovl_e'(cfg_overlap);
            fill      <= '0;
        end else if (in_valid) begin
            win <= cand;
            // a non-overlapping match restarts collection from scratch
            if (dec && ovl_q == OVL_OFF) begin
                fill <= '0;
            end else begin
                fill <= fill_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count <= '0;
        end else if (cnt_clr) begin
            hit_count <= '0;
        end else if (dec && hit_count != '1) begin
            hit_count <= hit_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_programmable_sequence_detector.sv
// Scoreboard bench: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against two DUT widths.
module tb_programmable_sequence_detector;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [15:0] cfg_pattern;
    logic [15:0] cfg_mask;
    logic [4:0]  cfg_len;
    logic        cfg_overlap;
    logic        cnt_clr;
    logic        in_valid;
    logic        din;
    logic        dec;
    logic [7:0]  hit_count;
    logic        primed;
    logic        dec2;
    logic [1:0]  hit_count2;
    logic        primed2;

    typedef struct {
        logic  dec;
        logic  pchk;
        logic  primed;
        int    cnt;
        int    cnt2;
        string tag;
    } exp_t;

    exp_t q[$];
    logic mon;
    int   m_cnt;
    int   m_cnt2;
    int   checks;
    int   errors;

    programmable_sequence_detector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .in_valid    (in_valid),
        .in          (din),
        .dec         (dec),
        .hit_count   (hit_count),
        .primed      (primed)
    );

    programmable_sequence_detector #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_pattern (cfg_pattern),
        .cfg_mask    (cfg_mask),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .in_valid    (in_valid),
        .in          (din),
        .dec         (dec2),
        .hit_count   (hit_count2),
        .primed      (primed2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string name, input string tag,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s/%s: got %0d expected %0d", tag, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: monitor found no expected entry");
            end else begin
                exp_t e;
                e = q.pop_front();
                cmp("dec", e.tag, int'(dec), int'(e.dec));
                cmp("dec_w2", e.tag, int'(dec2), int'(e.dec));
                cmp("hit_count", e.tag, int'(hit_count), e.cnt);
                cmp("hit_count_w2", e.tag, int'(hit_count2), e.cnt2);
                if (e.pchk) begin
                    cmp("primed", e.tag, int'(primed), int'(e.primed));
                    cmp("primed_w2", e.tag, int'(primed2), int'(e.primed));
                end
            end
        end
    end

    task automatic push(input logic exp_dec, input logic pchk,
                        input logic pexp, input logic r,
                        input logic clr, input string tag);
        exp_t e;
        e.dec    = exp_dec;
        e.pchk   = pchk;
        e.primed = pexp;
        e.cnt    = m_cnt;
        e.cnt2   = m_cnt2;
        e.tag    = tag;
        q.push_back(e);
        if (!r || clr) begin
            m_cnt  = 0;
            m_cnt2 = 0;
        end else if (exp_dec) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic step(input logic r, input logic v, input logic b,
                        input logic we, input logic clr,
                        input logic exp_dec, input string tag);
        @(posedge clk);
        #1;
        rst_n    = r;
        in_valid = v;
        din      = b;
        cfg_we   = we;
        cnt_clr  = clr;
        mon      = 1'b1;
        push(exp_dec, 1'b0, 1'b0, r, clr, tag);
    endtask

    task automatic probe(input logic pexp, input string tag);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        din      = 1'b0;
        cfg_we   = 1'b0;
        cnt_clr  = 1'b0;
        mon      = 1'b1;
        push(1'b0, 1'b1, pexp, 1'b1, 1'b0, tag);
    endtask

    task automatic cfg(input logic [15:0] p, input logic [15:0] m,
                       input logic [4:0] l, input logic o,
                       input logic clr, input logic v, input logic b,
                       input string tag);
        cfg_pattern = p;
        cfg_mask    = m;
        cfg_len     = l;
        cfg_overlap = o;
        step(1'b1, v, b, 1'b1, clr, 1'b0, tag);
    endtask

    task automatic stream(input logic [31:0] bits, input logic [31:0] exp,
                          input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(1'b1, 1'b1, bits[i], 1'b0, 1'b0, exp[i], tag);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_cnt = 0;
        m_cnt2 = 0;
        mon = 1'b0;
        rst_n = 1'b0;
        cfg_we = 1'b0;
        cfg_pattern = '0;
        cfg_mask = '0;
        cfg_len = '0;
        cfg_overlap = 1'b0;
        cnt_clr = 1'b0;
        in_valid = 1'b0;
        din = 1'b0;
        @(posedge clk);
        #1;

        // reset held with a live sample: no decision, counters cleared
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "rst_hold");
        probe(1'b0, "rst_primed");

        // default pattern with an idle cycle mid-stream
        stream(32'b1110, 32'b0000, 4, "dflt_a");
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "dflt_idle");
        stream(32'b0111, 32'b0001, 4, "dflt_b");
        probe(1'b1, "dflt_done");

        // partial match wiped by a mid-stream reset
        stream(32'b1110011, 32'b0000000, 7, "pre_rst");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "mid_rst");
        stream(32'b1, 32'b0, 1, "post_rst");
        probe(1'b0, "post_rst_primed");

        // len 4, overlapping
        cfg(16'h000B, 16'hFFFF, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, "cfg_ovl");
        stream(32'b1011011, 32'b0001001, 7, "ovl");
        probe(1'b1, "ovl_done");

        // len 4, non-overlapping
        cfg(16'h000B, 16'hFFFF, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, "cfg_novl");
        stream(32'b1011011, 32'b0001000, 7, "novl");
        probe(1'b0, "novl_done");

        // len 3 with a don't-care middle bit; upper bits are garbage
        cfg(16'hA5A5, 16'hFFFD, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, "cfg_mask");
        stream(32'b111, 32'b001, 3, "mask_111");
        cfg(16'hA5A5, 16'hFFFD, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_mask2");
        stream(32'b101, 32'b001, 3, "mask_101");
        probe(1'b1, "mask_done");

        // counter saturation on the 2-bit instance, then clear beats a hit
        cfg(16'h0003, 16'hFFFF, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, "cfg_sat");
        stream(32'b111111, 32'b011111, 6, "sat");
        probe(1'b1, "sat_done");
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "clr_hit");
        probe(1'b1, "clr_done");

        // config wins over a would-be matching sample; len 0 becomes 2
        cfg(16'h0003, 16'hFFFF, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, "cfg_collide");
        probe(1'b0, "collide_primed");
        stream(32'b11, 32'b01, 2, "len0");

        // oversize length clamps to the full 16-bit window
        cfg(16'hFFFF, 16'hFFFF, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, "cfg_big");
        stream(32'hFFFF, 32'h0001, 16, "big");
        probe(1'b1, "big_done");

        @(posedge clk);
        #1;
        mon = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
